// File: rtl/pong_io_controller.sv
// Memory-mapped I/O controller: RAM/I-O decode, scan-code FIFO, and vsync-aligned
// double-buffered ball/paddle coordinates for the pong renderer.
module pong_io_controller #(
    parameter int unsigned DMEM_LIMIT = 2000,
    parameter int unsigned IO_BASE    = 3000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BALL_X_RST = 320,
    parameter int unsigned BALL_Y_RST = 240,
    parameter int unsigned PADDLE_RST = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] proc_addr,
    input  logic [31:0] proc_data,
    input  logic        proc_wren,
    input  logic        proc_rden,
    output logic [31:0] proc_q,
    output logic        dmem_wren,
    input  logic [31:0] dmem_q,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_out,
    input  logic        vga_vsync,
    output logic [9:0]  ball_x,
    output logic [8:0]  ball_y,
    output logic [8:0]  paddle_left,
    output logic [8:0]  paddle_right
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [9:0]       shadow_x_q;
    logic [8:0]       shadow_y_q, shadow_l_q, shadow_r_q;
    logic [9:0]       ball_x_q;
    logic [8:0]       ball_y_q, paddle_l_q, paddle_r_q;
    logic             commit_q, overflow_q;
    logic [15:0]      frame_q;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [4:0]       count_q;
    logic             key_q;
    logic [1:0]       vs_sync_q;
    logic             vs_prev_q;
    logic             rd_valid_q, sel_ram_q;
    logic [31:0]      io_q, hold_q;

    logic        ram_sel, io_sel, key_rise, frame_tick;
    logic        fifo_full, pop, push, drop, status_rd, commit_wr;
    logic [3:0]  io_off;
    logic [31:0] io_rdata;
    logic        unused_data;

    assign unused_data = ^proc_data[31:10];

    always_comb begin
        ram_sel    = 32'(proc_addr) < DMEM_LIMIT;
        io_sel     = (32'(proc_addr) >= IO_BASE) && (32'(proc_addr) <= IO_BASE + 10);
        io_off     = 4'(32'(proc_addr) - IO_BASE);
        key_rise   = ps2_key_pressed & ~key_q;
        frame_tick = vs_sync_q[1] & ~vs_prev_q;
        fifo_full  = count_q == 5'(FIFO_DEPTH);
        pop        = proc_rden & io_sel & (io_off == 4'd8) & (count_q != 5'd0);
        // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
        push       = key_rise & (~fifo_full | pop);
        drop       = key_rise & fifo_full & ~pop;
        status_rd  = proc_rden & io_sel & (io_off == 4'd9);
        commit_wr  = proc_wren & io_sel & (io_off == 4'd4);
        dmem_wren  = proc_wren & ram_sel;

        io_rdata = '0;
        if (io_sel) begin
            case (io_off)
                4'd0:    io_rdata = {22'b0, shadow_x_q};
                4'd1:    io_rdata = {23'b0, shadow_y_q};
                4'd2:    io_rdata = {23'b0, shadow_l_q};
                4'd3:    io_rdata = {23'b0, shadow_r_q};
                4'd4:    io_rdata = {31'b0, commit_q};
                4'd8:    io_rdata = pop ? {23'b0, 1'b1, fifo_mem_q[rd_ptr_q]} : '0;
                4'd9:    io_rdata = {16'b0, frame_q[7:0], 2'b0, overflow_q, commit_q,
                                     count_q[3:0]};
                4'd10:   io_rdata = {16'b0, frame_q};
                default: io_rdata = '0;
            endcase
        end

        proc_q = rd_valid_q ? (sel_ram_q ? dmem_q : io_q) : hold_q;
    end

    assign ball_x       = ball_x_q;
    assign ball_y       = ball_y_q;
    assign paddle_left  = paddle_l_q;
    assign paddle_right = paddle_r_q;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= ps2_out;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_x_q <= 10'(BALL_X_RST);
            shadow_y_q <= 9'(BALL_Y_RST);
            shadow_l_q <= 9'(PADDLE_RST);
            shadow_r_q <= 9'(PADDLE_RST);
            ball_x_q   <= 10'(BALL_X_RST);
            ball_y_q   <= 9'(BALL_Y_RST);
            paddle_l_q <= 9'(PADDLE_RST);
            paddle_r_q <= 9'(PADDLE_RST);
            commit_q   <= 1'b0;
            overflow_q <= 1'b0;
            frame_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            key_q      <= 1'b0;
            vs_sync_q  <= '0;
            vs_prev_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            sel_ram_q  <= 1'b0;
            io_q       <= '0;
            hold_q     <= '0;
        end else begin
            if (proc_wren && io_sel) begin
                case (io_off)
                    4'd0:    shadow_x_q <= proc_data[9:0];
                    4'd1:    shadow_y_q <= proc_data[8:0];
                    4'd2:    shadow_l_q <= proc_data[8:0];
                    4'd3:    shadow_r_q <= proc_data[8:0];
                    default: ;
                endcase
            end

            if (frame_tick) begin
                frame_q <= frame_q + 16'd1;
                if (commit_q) begin
                    ball_x_q   <= shadow_x_q;
                    ball_y_q   <= shadow_y_q;
                    paddle_l_q <= shadow_l_q;
                    paddle_r_q <= shadow_r_q;
                end
            end

            // A commit landing on the tick re-arms for the following frame.
            if (commit_wr) begin
                commit_q <= 1'b1;
            end else if (frame_tick) begin
                commit_q <= 1'b0;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (status_rd) begin
                overflow_q <= 1'b0;
            end

            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: ;
            endcase

            key_q     <= ps2_key_pressed;
            vs_sync_q <= {vs_sync_q[0], vga_vsync};
            vs_prev_q <= vs_sync_q[1];

            rd_valid_q <= proc_rden;
            if (proc_rden) begin
                sel_ram_q <= ram_sel;
                io_q      <= io_rdata;
            end
            hold_q <= proc_q;
        end
    end
endmodule

// File: tb/tb_pong_io_controller.sv
// Randomised and directed bench for pong_io_controller: a behavioural model predicts every
// load result into a scoreboard queue, and a monitor compares when load data is presented.
module tb_pong_io_controller;
    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] proc_addr;
    logic [31:0] proc_data;
    logic        proc_wren, proc_rden;
    logic [31:0] proc_q;
    logic        dmem_wren;
    logic [31:0] dmem_q;
    logic        ps2_key_pressed;
    logic [7:0]  ps2_out;
    logic        vga_vsync;
    logic [9:0]  ball_x;
    logic [8:0]  ball_y, paddle_left, paddle_right;

    pong_io_controller #(
        .DMEM_LIMIT(2000), .IO_BASE(3000), .FIFO_DEPTH(DEPTH),
        .BALL_X_RST(320), .BALL_Y_RST(240), .PADDLE_RST(200)
    ) dut (
        .clock(clock), .reset(reset),
        .proc_addr(proc_addr), .proc_data(proc_data),
        .proc_wren(proc_wren), .proc_rden(proc_rden), .proc_q(proc_q),
        .dmem_wren(dmem_wren), .dmem_q(dmem_q),
        .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
        .vga_vsync(vga_vsync),
        .ball_x(ball_x), .ball_y(ball_y),
        .paddle_left(paddle_left), .paddle_right(paddle_right)
    );

    always #50 clock = ~clock;

    // Stand-in data RAM with registered output.
    bit [31:0] ram [4096];
    always @(posedge clock) begin
        if (dmem_wren) ram[proc_addr] <= proc_data;
        dmem_q <= ram[proc_addr];
    end

    // Reference model state.
    bit   [31:0] m_mem [4096];
    logic [31:0] m_shadow [4];
    logic [31:0] m_out [4];
    logic [31:0] mask [4] = '{32'h3FF, 32'h1FF, 32'h1FF, 32'h1FF};
    bit          m_pend, m_ovf;
    bit   [15:0] m_frame;
    bit   [7:0]  m_fifo [$];
    bit          m_kprev;
    bit          m_v1, m_v2, m_v3;  // vsync level seen 1, 2, 3 edges ago

    logic [31:0] exp_q [$];
    logic [31:0] last_q;
    int          n_cmp = 0;
    int          n_bad = 0;

    bit          key_lvl, vs_lvl;
    logic [7:0]  key_code;
    bit          rd_pend;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_shadow = '{32'd320, 32'd240, 32'd200, 32'd200};
        m_out    = '{32'd320, 32'd240, 32'd200, 32'd200};
        m_pend = 0; m_ovf = 0; m_frame = 0;
        m_fifo.delete();
        m_kprev = 0; m_v1 = 0; m_v2 = 0; m_v3 = 0;
        last_q = 0;
    endfunction

    // Effect of one clock edge with the given inputs applied.
    function automatic void model_edge(logic [11:0] a, logic [31:0] d, bit wr, bit rd,
                                       bit key, logic [7:0] code, bit vs);
        bit          tick = m_v2 && !m_v3;
        bit          rise = key && !m_kprev;
        bit          io   = (a >= 12'd3000) && (a <= 12'd3010);
        int          off  = int'(a) - 3000;
        bit          old_pend = m_pend;
        logic [31:0] old_sh [4];
        logic [31:0] rv = 0;
        old_sh = m_shadow;
        if (rd) begin
            if (a < 12'd2000) rv = m_mem[a];
            else if (io) begin
                case (off)
                    0, 1, 2, 3: rv = m_shadow[off];
                    4:  rv = {31'b0, m_pend};
                    8:  if (m_fifo.size() > 0) rv = 32'h100 | 32'(m_fifo.pop_front());
                    9:  begin
                            rv = {16'b0, m_frame[7:0], 2'b0, m_ovf, m_pend, 4'(m_fifo.size())};
                            m_ovf = 0;
                        end
                    10: rv = {16'b0, m_frame};
                    default: rv = 0;
                endcase
            end
            exp_q.push_back(rv);
        end
        if (rise) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(code);
            else m_ovf = 1;
        end
        if (wr && a < 12'd2000) m_mem[a] = d;
        if (wr && io && off < 4) m_shadow[off] = d & mask[off];
        if (tick) begin
            m_frame++;
            if (old_pend) m_out = old_sh;
        end
        m_pend = (wr && io && off == 4) ? 1'b1 : (tick ? 1'b0 : old_pend);
        m_v3 = m_v2; m_v2 = m_v1; m_v1 = vs;
        m_kprev = key;
    endfunction

    function automatic void check_outputs(string tag);
        check({tag, " ball_x"}, 32'(ball_x), m_out[0]);
        check({tag, " ball_y"}, 32'(ball_y), m_out[1]);
        check({tag, " paddle_left"}, 32'(paddle_left), m_out[2]);
        check({tag, " paddle_right"}, 32'(paddle_right), m_out[3]);
    endfunction

    task automatic step(logic [11:0] a, logic [31:0] d, bit wr, bit rd);
        @(negedge clock);
        proc_addr = a; proc_data = d; proc_wren = wr; proc_rden = rd;
        ps2_key_pressed = key_lvl; ps2_out = key_code; vga_vsync = vs_lvl;
        #1;
        check("dmem_wren", 32'(dmem_wren), 32'(wr && a < 12'd2000));
        model_edge(a, d, wr, rd, key_lvl, key_code, vs_lvl);
        @(posedge clock);
        #1;
        check_outputs("step");
    endtask

    task automatic st(int a, logic [31:0] d); step(12'(a), d, 1'b1, 1'b0); endtask
    task automatic ld(int a);                 step(12'(a), 32'd0, 1'b0, 1'b1); endtask
    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(12'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #20;
        reset = 1'b1;
        proc_wren = 0; proc_rden = 0; ps2_key_pressed = 0; vga_vsync = 0;
        key_lvl = 0; vs_lvl = 0;
        model_reset();
        exp_q.delete();
        #1;
        check_outputs("reset");
        check("reset proc_q", proc_q, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: load data is presented the cycle after proc_rden.
    always @(posedge clock or posedge reset) begin
        if (reset) rd_pend <= 1'b0;
        else       rd_pend <= proc_rden;
    end

    always @(negedge clock) begin
        if (rd_pend && !reset) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL load: got %h with no expected value queued", proc_q);
            end else begin
                last_q = exp_q.pop_front();
                check("load", proc_q, last_q);
            end
        end
    end

    logic [7:0] codes [5] = '{8'h1D, 8'h1B, 8'h23, 8'h2B, 8'h1C};

    initial begin
        reset = 1'b1;
        proc_addr = 0; proc_data = 0; proc_wren = 0; proc_rden = 0;
        ps2_key_pressed = 0; ps2_out = 0; vga_vsync = 0;
        key_lvl = 0; vs_lvl = 0; key_code = 0;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        check_outputs("reset");
        check("reset proc_q", proc_q, 32'd0);
        reset = 1'b0;

        ld(3009);
        idle(1);

        // RAM boundary and load latency, then hold while RAM output moves.
        st(1999, 32'h55);
        st(2000, 32'h66);
        ld(1999);
        ld(2000);
        ld(1999);
        idle(3);
        check("hold", proc_q, last_q);

        // Commit through vsync.
        st(3000, 32'd100);
        st(3004, 32'd1);
        vs_lvl = 1;
        idle(4);
        vs_lvl = 0;
        idle(2);
        ld(3009);
        ld(3000);
        idle(1);

        // Five pushes into a depth-4 FIFO.
        foreach (codes[i]) begin
            key_lvl = 1; key_code = codes[i]; idle(1);
            key_lvl = 0; idle(1);
        end
        ld(3009);
        for (int i = 0; i < 5; i++) ld(3008);
        ld(3009);
        idle(1);

        // Full FIFO with push and pop on the same edge.
        for (int i = 0; i < 4; i++) begin
            key_lvl = 1; key_code = 8'h30 + 8'(i); idle(1);
            key_lvl = 0; idle(1);
        end
        key_lvl = 1; key_code = 8'h42;
        ld(3008);
        key_lvl = 0;
        ld(3009);
        for (int i = 0; i < 4; i++) ld(3008);
        ld(3009);
        idle(1);

        // Three frames without a commit.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vs_lvl = 1; idle(2);
            vs_lvl = 0; idle(3);
        end
        ld(3010);
        idle(1);

        // Reset while a commit is pending.
        st(3000, 32'd17); st(3001, 32'd18); st(3002, 32'd19); st(3003, 32'd20);
        st(3004, 32'd0);
        vs_lvl = 1; idle(1);
        do_reset();
        idle(4);
        ld(3009);
        ld(3004);
        idle(1);

        // Randomised traffic around decode boundaries.
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            int unsigned op;
            logic [11:0] a;
            r = $urandom_range(0, 2);
            case (r)
                0:       a = 12'(1990 + $urandom_range(0, 19));
                1:       a = 12'(2998 + $urandom_range(0, 14));
                default: a = 12'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) key_lvl = ~key_lvl;
            key_code = 8'($urandom);
            if ($urandom_range(0, 5) == 0) vs_lvl = ~vs_lvl;
            op = $urandom_range(0, 2);
            step(a, $urandom, op == 1, op == 2);
        end
        idle(2);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d loads unpresented expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
